// File: rtl/free_list_pkg.sv
// Shared sizing and types for the rename free list: tag widths, ring depth
// and a modulo-depth pointer helper.
package free_list_pkg;

    localparam int unsigned N           = 3;
    localparam int unsigned ARCH_REG_SZ = 32;
    localparam int unsigned PHYS_REG_SZ = 64;
    localparam int unsigned FL_DEPTH    = PHYS_REG_SZ - ARCH_REG_SZ;

    localparam int unsigned TAG_W   = $clog2(PHYS_REG_SZ);
    localparam int unsigned IDX_W   = $clog2(FL_DEPTH);
    localparam int unsigned COUNT_W = $clog2(FL_DEPTH + 1);
    localparam int unsigned SLOT_W  = $clog2(N + 1);

    typedef logic [TAG_W-1:0] phys_tag_t;
    typedef logic [IDX_W-1:0] free_list_idx_t;

    // Ring depth need not be a power of two, so wrap by explicit subtraction.
    function automatic free_list_idx_t wrap_add(free_list_idx_t base, int unsigned offset);
        int unsigned sum;
        sum = 32'(base) + offset;
        if (sum >= FL_DEPTH) begin
            sum = sum - FL_DEPTH;
        end
        return free_list_idx_t'(sum);
    endfunction

endpackage

// File: rtl/free_list.sv
// Physical-register free list: a circular buffer with a speculative head for
// dispatch, an architected head for retire, and single-cycle mispredict restore.
module free_list
    import free_list_pkg::*;
#(
    parameter int unsigned NUM_FREE_PORTS = N
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic      [N-1:0]                    alloc_req,
    output phys_tag_t [N-1:0]                    alloc_tags,
    output logic      [N-1:0]                    alloc_valid,
    input  logic      [NUM_FREE_PORTS-1:0]       free_valid,
    input  phys_tag_t [NUM_FREE_PORTS-1:0]       free_tags,
    input  logic                                 restore_en,
    output logic      [SLOT_W-1:0]               free_slots,
    output logic      [COUNT_W-1:0]              free_count
);

    phys_tag_t      entries [FL_DEPTH];
    free_list_idx_t spec_head;
    free_list_idx_t arch_head;
    free_list_idx_t tail;

    int unsigned    grant_count;
    int unsigned    free_total;
    int unsigned    next_count;

    // Number of set bits strictly below a lane: the lane's offset from its head.
    function automatic int unsigned count_below(logic [31:0] bits, int unsigned lane);
        int unsigned total;
        total = 0;
        for (int unsigned j = 0; j < 32; j++) begin
            if (j < lane && bits[j]) begin
                total = total + 1;
            end
        end
        return total;
    endfunction

    // Grants come only from registered state; this cycle's frees are not visible here.
    always_comb begin
        alloc_valid = '0;
        alloc_tags  = '0;
        grant_count = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (alloc_req[i] && !reset && !restore_en &&
                count_below(32'(alloc_req), i) < 32'(free_count)) begin
                alloc_valid[i] = 1'b1;
                alloc_tags[i]  = entries[wrap_add(spec_head, count_below(32'(alloc_req), i))];
                grant_count    = grant_count + 1;
            end
        end
    end

    always_comb begin
        free_total = count_below(32'(free_valid), NUM_FREE_PORTS);
        next_count = 32'(free_count) - grant_count + free_total;
        if (next_count > FL_DEPTH) begin
            next_count = FL_DEPTH;
        end
    end

    assign free_slots = (32'(free_count) >= N) ? SLOT_W'(N) : SLOT_W'(free_count);

    // Frees land at the tail in lane order and move the architected head in
    // lockstep; restore rewinds the speculative head to the post-free architected head.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned k = 0; k < FL_DEPTH; k++) begin
                entries[k] <= phys_tag_t'(ARCH_REG_SZ + k);
            end
            spec_head  <= '0;
            arch_head  <= '0;
            tail       <= '0;
            free_count <= COUNT_W'(FL_DEPTH);
        end else begin
            for (int unsigned j = 0; j < NUM_FREE_PORTS; j++) begin
                if (free_valid[j]) begin
                    entries[wrap_add(tail, count_below(32'(free_valid), j))] <= free_tags[j];
                end
            end
            tail      <= wrap_add(tail, free_total);
            arch_head <= wrap_add(arch_head, free_total);
            if (restore_en) begin
                spec_head  <= wrap_add(arch_head, free_total);
                free_count <= COUNT_W'(FL_DEPTH);
            end else begin
                spec_head  <= wrap_add(spec_head, grant_count);
                free_count <= COUNT_W'(next_count);
            end
        end
    end

endmodule
